stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//   Registered N-channel stream multiplexer; parametrised successor of the fixed 4:1 mux.
//   Selects one of CH valid/ready input channels, either by an explicit select or by round-robin.
//   Registers the chosen word into a single output stage with valid/ready backpressure.
//   Sits between parallel producers and one shared consumer, e.g. a shared bus or UART TX.
// PARAMETERS
//   CH   4                 number of input channels; minimum 2, need not be a power of 2
//   DW   8                 data width per channel, in bits
//   SW   $clog2(CH)        select/channel-index width; derived localparam, not overridable
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   in_data    in   CH*DW   channel i occupies bits [i*DW +: DW]
//   in_valid   in   CH      per-channel valid
//   in_ready   out  CH      per-channel ready; one-hot or zero
//   mode       in   1       0 = FIXED (use sel), 1 = ROUND-ROBIN
//   sel        in   SW      channel index used in FIXED mode
//   out_data   out  DW      registered output word
//   out_ch     out  SW      index of the channel that out_data came from
//   out_valid  out  1       output word valid
//   out_ready  in   1       consumer ready
// BEHAVIOUR
//   - Reset: out_valid=0, out_data=0, out_ch=0, rr_ptr=CH-1, so the first RR search starts at channel 0.
//   - load_en = !out_valid || out_ready. The output stage accepts a new word when it is empty or draining.
//   - Grant (combinational):
//       FIXED: grant = sel if sel < CH and in_valid[sel]; otherwise no grant.
//       RR: first i with in_valid[i] set, searching rr_ptr+1, rr_ptr+2, ... with wrap mod CH.
//   - in_ready[g] = load_en && grant_valid && (g == grant). All other in_ready bits are 0.
//   - Transfer on channel g when in_valid[g] && in_ready[g]. At the next edge:
//       out_data <= channel g data; out_ch <= g; out_valid <= 1; rr_ptr <= g.
//   - rr_ptr updates only on a transfer, in either mode. FIXED-mode traffic therefore moves the RR origin.
//   - If load_en && out_ready && no grant, out_valid <= 0 at the next edge.
//   - If out_valid && !out_ready, out_data and out_ch hold stable and all in_ready bits are 0.
//   - Latency 1 cycle from input handshake to out_valid. Throughput 1 word/cycle with out_ready held high.
//   - Drain and refill in the same cycle is supported (back-to-back words with no bubble).
//   - mode/sel changes affect only the next grant decision; a word already held is never altered.
//   - FIXED with sel >= CH (non-power-of-2 CH): no grant, in_ready=0. Not an error.
//   - RR fairness: with all channels valid and out_ready=1, grants rotate 0,1,...,CH-1,0,...
//   - RR wrap: rr_ptr=CH-1 searches from 0.
//   - Reset mid-operation: the held output word is discarded; no in_ready is asserted in the reset cycle.
//   - in_valid is assumed sticky until handshake (AXI-style). The block itself does not depend on this.
// STRUCTURE
//   Shared package/header stream_mux_defs:
//     MODE_FIXED = 1'b0, MODE_RR = 1'b1
//     clog2 helper macro/function
//   Sub-module rr_pick #(CH):
//     inputs: req[CH], base[SW]
//     outputs: gnt_idx[SW], gnt_valid
//     Rotating-priority search via a doubled request vector. Pure combinational.
//   Top level holds load_en, the fixed/RR grant mux, the output register and rr_ptr.
// TESTING (CH=4, DW=8 unless noted)
//   1. Reset, then mode=0, sel=2, in_valid=4'b0100, data2=8'hA5, out_ready=1
//      -> in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_ch=2.
//   2. mode=1, in_valid=4'b1111 held, out_ready=1, 8 cycles
//      -> out_ch sequence 0,1,2,3,0,1,2,3; in_ready one-hot every cycle.
//   3. mode=1, in_valid=4'b1001, rr_ptr at 3 -> grant 0 (wrap), then 3, then 0.
//   4. Output full, out_ready=0 for 3 cycles with all inputs valid
//      -> in_ready=0, out_data/out_ch stable; on out_ready=1 the next word loads with no bubble.
//   5. Assert rst while out_valid=1, out_ready=0 -> next cycle out_valid=0, out_data=0, out_ch=0.
//      First RR grant afterwards is channel 0.
//   6. CH=3, mode=0, sel=3, in_valid=3'b111 -> in_ready=0, out_valid falls to 0 after draining.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
package stream_mux_rr_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Ceiling log2, used to size channel-index fields.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// Rotating-priority picker: first set request after base, wrapping mod CH.
module rr_pick
  import stream_mux_rr_pkg::*;
#(
  parameter  int unsigned CH = 4,
  localparam int unsigned SW = clog2(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [SW-1:0] base,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [2*CH-1:0] reqDbl;
  logic [2*CH-1:0] reqRot;
  logic [SW-1:0]   startIdx;
  logic [SW:0]     sumIdx;

  assign reqDbl = {req, req};

  // Search origin is the channel after base; base at or past the last channel wraps to 0.
  always_comb begin
    startIdx = '0;
    if (base < SW'(CH - 1)) begin
      startIdx = base + 1'b1;
    end
  end

  // Doubled vector shifted down by the origin gives the requests in priority order.
  assign reqRot = reqDbl >> startIdx;

  // First set bit of the rotated window, mapped back to an absolute channel index.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sumIdx    = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (!gnt_valid && reqRot[i]) begin
        gnt_valid = 1'b1;
        sumIdx    = {1'b0, startIdx} + (SW+1)'(i);
        if (sumIdx >= (SW+1)'(CH)) begin
          sumIdx = sumIdx - (SW+1)'(CH);
        end
        gnt_idx = sumIdx[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered CH-channel stream multiplexer with fixed-select or round-robin grant.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter  int unsigned CH = 4,
  parameter  int unsigned DW = 8,
  localparam int unsigned SW = clog2(CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH*DW-1:0] in_data,
  input  logic [CH-1:0]    in_valid,
  output logic [CH-1:0]    in_ready,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  output logic [DW-1:0]    out_data,
  output logic [SW-1:0]    out_ch,
  output logic             out_valid,
  input  logic             out_ready
);

  mode_e         modeSel;
  logic          loadEn;
  logic          fixValid;
  logic          rrValid;
  logic [SW-1:0] rrIdx;
  logic          grantValid;
  logic [SW-1:0] grantIdx;
  logic [SW-1:0] rrPtr;

  assign modeSel = mode_e'(mode);

  // Output stage can take a word when empty or being drained this cycle.
  assign loadEn = !out_valid || out_ready;

  rr_pick #(.CH(CH)) uPick (
    .req       (in_valid),
    .base      (rrPtr),
    .gnt_idx   (rrIdx),
    .gnt_valid (rrValid)
  );

  // Fixed-mode grant: only an in-range select on a valid channel wins.
  always_comb begin
    fixValid = 1'b0;
    if ({1'b0, sel} < (SW+1)'(CH)) begin
      fixValid = in_valid[sel];
    end
  end

  // Grant source follows the current mode.
  always_comb begin
    grantValid = fixValid;
    grantIdx   = sel;
    if (modeSel == MODE_RR) begin
      grantValid = rrValid;
      grantIdx   = rrIdx;
    end
  end

  // One-hot ready to the granted channel; suppressed during reset.
  always_comb begin
    in_ready = '0;
    if (!rst && loadEn && grantValid) begin
      in_ready[grantIdx] = 1'b1;
    end
  end

  // Output register and round-robin origin; both advance only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rrPtr     <= SW'(CH - 1);
    end else if (loadEn) begin
      if (grantValid) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grantIdx*DW +: DW];
        out_ch    <= grantIdx;
        rrPtr     <= grantIdx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a CH=4 instance and a CH=3 instance.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst;

  logic [31:0] inData4;
  logic [3:0]  inValid4;
  logic [3:0]  inReady4;
  logic        mode4;
  logic [1:0]  sel4;
  logic [7:0]  outData4;
  logic [1:0]  outCh4;
  logic        outValid4;
  logic        outReady4;

  logic [23:0] inData3;
  logic [2:0]  inValid3;
  logic [2:0]  inReady3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [7:0]  outData3;
  logic [1:0]  outCh3;
  logic        outValid3;
  logic        outReady3;

  int unsigned vecCount;
  int unsigned errCount;

  logic [7:0]  chData [4];

  stream_mux_rr #(.CH(4), .DW(8)) uDut4 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (inData4),
    .in_valid  (inValid4),
    .in_ready  (inReady4),
    .mode      (mode4),
    .sel       (sel4),
    .out_data  (outData4),
    .out_ch    (outCh4),
    .out_valid (outValid4),
    .out_ready (outReady4)
  );

  stream_mux_rr #(.CH(3), .DW(8)) uDut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (inData3),
    .in_valid  (inValid3),
    .in_ready  (inReady3),
    .mode      (mode3),
    .sel       (sel3),
    .out_data  (outData3),
    .out_ch    (outCh3),
    .out_valid (outValid3),
    .out_ready (outReady3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at a falling edge with reset applied for one rising edge and released.
  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    inValid4 = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecCount  = 0;
    errCount  = 0;
    chData[0] = 8'h11;
    chData[1] = 8'h22;
    chData[2] = 8'hA5;
    chData[3] = 8'h44;
    rst       = 1'b1;
    inData4   = {8'h44, 8'hA5, 8'h22, 8'h11};
    inValid4  = '0;
    mode4     = 1'b0;
    sel4      = '0;
    outReady4 = 1'b0;
    inData3   = {8'h33, 8'h32, 8'h31};
    inValid3  = '0;
    mode3     = 1'b0;
    sel3      = '0;
    outReady3 = 1'b0;

    // Reset state, with all inputs valid to show ready stays low in reset
    @(negedge clk);
    inValid4  = 4'b1111;
    mode4     = 1'b1;
    outReady4 = 1'b1;
    #1;
    checkVal("rst_in_ready", 32'(inReady4), 32'h0);
    @(negedge clk);
    checkVal("rst_out_valid", 32'(outValid4), 32'h0);
    checkVal("rst_out_data", 32'(outData4), 32'h0);
    checkVal("rst_out_ch", 32'(outCh4), 32'h0);

    // Test 1: fixed select of channel 2
    rst      = 1'b0;
    mode4    = 1'b0;
    sel4     = 2'd2;
    inValid4 = 4'b0100;
    #1;
    checkVal("t1_in_ready", 32'(inReady4), 32'h4);
    @(negedge clk);
    checkVal("t1_out_valid", 32'(outValid4), 32'h1);
    checkVal("t1_out_data", 32'(outData4), 32'hA5);
    checkVal("t1_out_ch", 32'(outCh4), 32'h2);
    inValid4 = 4'b0000;

    // Test 2: round-robin fairness, all channels valid
    doReset();
    mode4     = 1'b1;
    inValid4  = 4'b1111;
    outReady4 = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      #1;
      checkVal("t2_in_ready", 32'(inReady4), 32'h1 << (k % 4));
      @(negedge clk);
      checkVal("t2_out_ch", 32'(outCh4), k % 4);
      checkVal("t2_out_data", 32'(outData4), 32'(chData[k % 4]));
      checkVal("t2_out_valid", 32'(outValid4), 32'h1);
    end

    // Test 3: wrap from rr_ptr=3 with channels 0 and 3 valid
    doReset();
    mode4    = 1'b1;
    inValid4 = 4'b1001;
    for (int unsigned k = 0; k < 3; k++) begin
      #1;
      checkVal("t3_in_ready", 32'(inReady4), (k == 1) ? 32'h8 : 32'h1);
      @(negedge clk);
      checkVal("t3_out_ch", 32'(outCh4), (k == 1) ? 32'h3 : 32'h0);
    end

    // Test 4: backpressure holds the word, then refill without a bubble
    inValid4  = 4'b1111;
    outReady4 = 1'b0;
    #1;
    checkVal("t4_in_ready_stall", 32'(inReady4), 32'h0);
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      checkVal("t4_hold_ch", 32'(outCh4), 32'h0);
      checkVal("t4_hold_data", 32'(outData4), 32'h11);
      checkVal("t4_hold_valid", 32'(outValid4), 32'h1);
      #1;
      checkVal("t4_in_ready_stall", 32'(inReady4), 32'h0);
    end
    outReady4 = 1'b1;
    #1;
    checkVal("t4_in_ready_resume", 32'(inReady4), 32'h2);
    @(negedge clk);
    checkVal("t4_refill_valid", 32'(outValid4), 32'h1);
    checkVal("t4_refill_ch", 32'(outCh4), 32'h1);
    checkVal("t4_refill_data", 32'(outData4), 32'h22);
    #1;
    checkVal("t4_in_ready_next", 32'(inReady4), 32'h4);

    // Test 5: reset while a word is held under backpressure
    outReady4 = 1'b0;
    rst       = 1'b1;
    #1;
    checkVal("t5_in_ready_rst", 32'(inReady4), 32'h0);
    @(negedge clk);
    checkVal("t5_out_valid", 32'(outValid4), 32'h0);
    checkVal("t5_out_data", 32'(outData4), 32'h0);
    checkVal("t5_out_ch", 32'(outCh4), 32'h0);
    rst       = 1'b0;
    outReady4 = 1'b1;
    #1;
    checkVal("t5_first_grant", 32'(inReady4), 32'h1);
    @(negedge clk);
    checkVal("t5_first_ch", 32'(outCh4), 32'h0);
    checkVal("t5_first_data", 32'(outData4), 32'h11);
    inValid4 = '0;

    // Test 6: CH=3, out-of-range select gives no grant and the output drains
    mode3     = 1'b0;
    sel3      = 2'd2;
    inValid3  = 3'b111;
    outReady3 = 1'b1;
    #1;
    checkVal("t6_in_ready_sel2", 32'(inReady3), 32'h4);
    @(negedge clk);
    checkVal("t6_out_valid", 32'(outValid3), 32'h1);
    checkVal("t6_out_data", 32'(outData3), 32'h33);
    checkVal("t6_out_ch", 32'(outCh3), 32'h2);
    sel3 = 2'd3;
    #1;
    checkVal("t6_in_ready_sel3", 32'(inReady3), 32'h0);
    @(negedge clk);
    checkVal("t6_drained_valid", 32'(outValid3), 32'h0);
    checkVal("t6_drained_data", 32'(outData3), 32'h33);
    #1;
    checkVal("t6_in_ready_idle", 32'(inReady3), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
